// File: rtl/hazard_unit.sv
// Five-stage core hazard controller: shadow E/M/W tags, operand forwarding,
// load-use stall, taken-branch flush and saturating event counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       RD_D,
    input  logic             RegWriteD,
    input  logic             ResultSrcD,
    input  logic             PCSrcE,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // p0 = Execute slot, p1 = Memory slot, p2 = Writeback slot
    logic [4:0] rs1_p0, rs2_p0, rd_p0;
    logic       reg_write_p0, load_p0;
    logic [4:0] rd_p1;
    logic       reg_write_p1;
    logic [4:0] rd_p2;
    logic       reg_write_p2;

    logic       lw_stall;
    logic       stall_evt;
    logic       flush_evt;

    // Memory result wins over Writeback because it is the younger producer.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] rd_m, input logic rw_m,
                                           input logic [4:0] rd_w, input logic rw_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rw_m && (rd_m != 5'd0) && (rd_m == src))
            sel = 2'b10;
        else if (rw_w && (rd_w != 5'd0) && (rd_w == src))
            sel = 2'b01;
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    assign lw_stall = load_p0 && reg_write_p0 && (rd_p0 != 5'd0) &&
                      ((rd_p0 == Rs1_D) || (rd_p0 == Rs2_D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign stall_evt = rst && lw_stall && !PCSrcE;
    assign flush_evt = rst && PCSrcE;

    assign ForwardA_E = rst ? fwd_sel(rs1_p0, rd_p1, reg_write_p1, rd_p2, reg_write_p2) : 2'b00;
    assign ForwardB_E = rst ? fwd_sel(rs2_p0, rd_p1, reg_write_p1, rd_p2, reg_write_p2) : 2'b00;

    // Stage boundary: Decode -> E -> M -> W shadow advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_p0       <= 5'd0;
            rs2_p0       <= 5'd0;
            rd_p0        <= 5'd0;
            reg_write_p0 <= 1'b0;
            load_p0      <= 1'b0;
            rd_p1        <= 5'd0;
            reg_write_p1 <= 1'b0;
            rd_p2        <= 5'd0;
            reg_write_p2 <= 1'b0;
        end else begin
            rd_p2        <= rd_p1;
            reg_write_p2 <= reg_write_p1;
            rd_p1        <= rd_p0;
            reg_write_p1 <= reg_write_p0;
            if (FlushE) begin
                rs1_p0       <= 5'd0;
                rs2_p0       <= 5'd0;
                rd_p0        <= 5'd0;
                reg_write_p0 <= 1'b0;
                load_p0      <= 1'b0;
            end else begin
                rs1_p0       <= Rs1_D;
                rs2_p0       <= Rs2_D;
                rd_p0        <= RD_D;
                reg_write_p0 <= RegWriteD;
                load_p0      <= ResultSrcD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_evt)
                StallCount <= sat_inc(StallCount);
            if (flush_evt)
                FlushCount <= sat_inc(FlushCount);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed instruction sequences, expectations
// queued at issue time and checked by an independent monitor on the falling edge.
module tb_hazard_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       Rs1_D, Rs2_D, RD_D;
    logic             RegWriteD, ResultSrcD, PCSrcE;
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] StallCount, FlushCount;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1_D      (Rs1_D),
        .Rs2_D      (Rs2_D),
        .RD_D       (RD_D),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .ForwardA_E (ForwardA_E),
        .ForwardB_E (ForwardB_E),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control group packing: {StallF, StallD, FlushD, FlushE}
    localparam int C_NONE  = 0;
    localparam int C_STALL = 13;
    localparam int C_FLUSH = 3;

    int    exp_fa_q[$], exp_fb_q[$], exp_ctrl_q[$], exp_sc_q[$], exp_fc_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic step(input string name, input int rs1, input int rs2, input int rd,
                        input int rw, input int ld, input int pc,
                        input int fa, input int fb, input int ctrl,
                        input int sc, input int fc, input int drop_rst);
        @(posedge clk);
        #1;
        Rs1_D      = 5'(rs1);
        Rs2_D      = 5'(rs2);
        RD_D       = 5'(rd);
        RegWriteD  = 1'(rw);
        ResultSrcD = 1'(ld);
        PCSrcE     = 1'(pc);
        name_q.push_back(name);
        exp_fa_q.push_back(fa);
        exp_fb_q.push_back(fb);
        exp_ctrl_q.push_back(ctrl);
        exp_sc_q.push_back(sc);
        exp_fc_q.push_back(fc);
        if (drop_rst != 0) begin
            #2;
            rst = 1'b0;
        end
    endtask

    task automatic nop(input string name, input int pc, input int ctrl, input int sc, input int fc);
        step(name, 0, 0, 0, 0, 0, pc, 0, 0, ctrl, sc, fc, 0);
    endtask

    // Monitor: every falling edge with an outstanding expectation is compared.
    initial begin
        string nm;
        int    fa, fb, ctrl, sc, fc, got_ctrl;
        forever begin
            @(negedge clk);
            if (name_q.size() > 0) begin
                nm   = name_q.pop_front();
                fa   = exp_fa_q.pop_front();
                fb   = exp_fb_q.pop_front();
                ctrl = exp_ctrl_q.pop_front();
                sc   = exp_sc_q.pop_front();
                fc   = exp_fc_q.pop_front();
                got_ctrl = int'({StallF, StallD, FlushD, FlushE});

                n_checks++;
                if (int'(ForwardA_E) != fa || int'(ForwardB_E) != fb) begin
                    n_fail++;
                    $display("FAIL %s fwd: got A=%0d B=%0d expected A=%0d B=%0d",
                             nm, ForwardA_E, ForwardB_E, fa, fb);
                end
                n_checks++;
                if (got_ctrl != ctrl) begin
                    n_fail++;
                    $display("FAIL %s ctrl{SF,SD,FD,FE}: got %04b expected %04b",
                             nm, got_ctrl[3:0], ctrl[3:0]);
                end
                n_checks++;
                if (int'(StallCount) != sc || int'(FlushCount) != fc) begin
                    n_fail++;
                    $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             nm, StallCount, FlushCount, sc, fc);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        Rs1_D = '0; Rs2_D = '0; RD_D = '0;
        RegWriteD = 1'b0; ResultSrcD = 1'b0; PCSrcE = 1'b0;
        #1 rst = 1'b0;

        // Reset holds everything at zero even with a branch and a load presented
        step("reset_forced", 5, 5, 5, 1, 1, 1, 0, 0, C_NONE, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b1;
        Rs1_D = '0; Rs2_D = '0; RD_D = '0;
        RegWriteD = 1'b0; ResultSrcD = 1'b0; PCSrcE = 1'b0;
        nop("after_reset", 0, C_NONE, 0, 0);

        // Test 1: add x5 ; add x6,x5,x1
        step("t1_add5",   1, 2, 5, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t1_add6",   5, 1, 6, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t1_fwdM",   0, 0, 0, 0, 0, 0, 2, 0, C_NONE, 0, 0, 0);

        // Test 2: add x5 ; unrelated ; sub x7,x2,x5
        step("t2_add5",   3, 4, 5, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t2_add8",   9, 10, 8, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t2_sub7",   2, 5, 7, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t2_fwdW",   0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 0, 0, 0);

        // Test 3: addi x5 ; add x5 ; add x9,x5,x6 -> M wins
        step("t3_addi5",  1, 0, 5, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t3_add5",   2, 3, 5, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t3_add9",   5, 6, 9, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t3_Mwins",  0, 0, 0, 0, 0, 0, 2, 0, C_NONE, 0, 0, 0);

        // Test 4: lw x5 ; add x6,x5,x1 -> one stall, then forward from W
        step("t4_lw5",    1, 0, 5, 1, 1, 0, 0, 0, C_NONE, 0, 0, 0);
        step("t4_stall",  5, 1, 6, 1, 0, 0, 0, 0, C_STALL, 0, 0, 0);
        step("t4_held",   5, 1, 6, 1, 0, 0, 0, 0, C_NONE, 1, 0, 0);
        step("t4_fwdW",   0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 1, 0, 0);

        // Test 5: x0 is never forwarded and never stalls
        step("t5_lw0",    1, 0, 0, 1, 1, 0, 0, 0, C_NONE, 1, 0, 0);
        step("t5_use0",   0, 0, 6, 1, 0, 0, 0, 0, C_NONE, 1, 0, 0);
        step("t5_addi0",  1, 0, 0, 1, 0, 0, 0, 0, C_NONE, 1, 0, 0);
        step("t5_use0b",  0, 0, 7, 1, 0, 0, 0, 0, C_NONE, 1, 0, 0);
        step("t5_x0M",    0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 0);
        step("t5_x0W",    0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 0);

        // Test 6a: taken branch overrides a load-use match
        step("t6_lw5",    1, 0, 5, 1, 1, 0, 0, 0, C_NONE, 1, 0, 0);
        step("t6_brlu",   5, 1, 6, 1, 0, 1, 0, 0, C_FLUSH, 1, 0, 0);
        nop("t6_after", 0, C_NONE, 1, 1);

        // Test 6b: back-to-back flushes up to and past saturation
        for (int i = 0; i < 15; i++)
            nop($sformatf("t6_flush%0d", i), 1, C_FLUSH, 1, 1 + i);
        nop("t6_sat", 0, C_NONE, 1, 15);

        // Test 6c: reset dropped in the middle of a stall cycle
        step("t6_lw5b",   1, 0, 5, 1, 1, 0, 0, 0, C_NONE, 1, 15, 0);
        step("t6_rstmid", 5, 1, 6, 1, 0, 0, 0, 0, C_NONE, 0, 0, 1);
        @(posedge clk); #1 rst = 1'b1;
        Rs1_D = '0; Rs2_D = '0; RD_D = '0;
        RegWriteD = 1'b0; ResultSrcD = 1'b0; PCSrcE = 1'b0;
        nop("t6_postrst", 0, C_NONE, 0, 0);

        for (int i = 0; i < 5 && name_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (name_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", name_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
